// File: rtl/univ_shift_pkg.sv
// Shared types and opcode decode for the universal shift sequencer.
// UNIV_SHIFT_ROTATE_EN enables the ROR/ROL opcodes; otherwise they decode as reserved.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ASR  = 3'd5,
    OP_RSVD = 3'd6
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int OP_W = 3;

  // Opcodes that consume the shift amount; everything else finishes after one cycle.
  function automatic logic is_shift_op(input logic [OP_W-1:0] o);
    case (o)
      OP_SHR, OP_SHL, OP_ASR: return 1'b1;
`ifdef UNIV_SHIFT_ROTATE_EN
      OP_ROR, OP_ROL:         return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/univ_shift_step.sv
// Combinational single-step next-value function of the shift sequencer.
// UNIV_SHIFT_ROTATE_EN adds the rotate legs to the mux.
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [n-1:0]    q,
  input  logic [OP_W-1:0] op,
  input  logic            r_serialin,
  input  logic            l_serialin,
  output logic [n-1:0]    q_next,
  output logic            bit_out
);

  always_comb begin
    q_next  = q;
    bit_out = 1'b0;
    case (op)
      OP_SHR: begin
        q_next  = {r_serialin, q[n-1:1]};
        bit_out = q[0];
      end
      OP_SHL: begin
        q_next  = {q[n-2:0], l_serialin};
        bit_out = q[n-1];
      end
`ifdef UNIV_SHIFT_ROTATE_EN
      OP_ROR: begin
        q_next  = {q[0], q[n-1:1]};
        bit_out = q[0];
      end
      OP_ROL: begin
        q_next  = {q[n-2:0], q[n-1]};
        bit_out = q[n-1];
      end
`endif
      OP_ASR: begin
        q_next  = {q[n-1], q[n-1:1]};
        bit_out = q[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_seq.sv
// Universal shift sequencer: executes LOAD/shift/rotate commands one bit per clock.
// UNIV_SHIFT_ROTATE_EN enables ROR/ROL; without it those opcodes act as reserved.
module univ_shift_seq
  import univ_shift_pkg::*;
#(
  parameter int n  = 8,
  parameter int AW = $clog2(n) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [n-1:0]  d,
  input  logic          abort,
  input  logic          r_serialin,
  input  logic          l_serialin,
  output logic [n-1:0]  q,
  output logic          serial_out,
  output logic          busy,
  output logic          done
);

  state_t          state, state_nx;
  logic [OP_W-1:0] op_r;
  logic [AW-1:0]   cnt;
  logic [n-1:0]    q_step;
  logic            bit_step;
  logic            accept, step_en, finish, last;

  univ_shift_step #(.n(n)) u_step (
    .q          (q),
    .op         (op_r),
    .r_serialin (r_serialin),
    .l_serialin (l_serialin),
    .q_next     (q_step),
    .bit_out    (bit_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start)          state_nx = ST_RUN;
      ST_RUN:  if (abort || last)  state_nx = ST_IDLE;
      default:                     state_nx = ST_IDLE;
    endcase
  end

  // Abort outranks both the step and the completion pulse on the same edge.
  always_comb begin
    last    = (cnt <= AW'(1));
    accept  = (state == ST_IDLE) && start;
    step_en = (state == ST_RUN) && !abort && (cnt != '0);
    finish  = (state == ST_RUN) && !abort && last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      op_r       <= OP_LOAD;
    end else begin
      busy <= (state_nx == ST_RUN);
      done <= finish;
      if (accept) begin
        op_r <= op;
        cnt  <= is_shift_op(op) ? amt : '0;
        if (op == OP_LOAD) q <= d;
      end else if (step_en) begin
        q          <= q_step;
        serial_out <= bit_step;
        cnt        <= cnt - AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_seq.sv
// Self-checking bench for univ_shift_seq (n=6) with a cycle-level behavioural model.
module tb_univ_shift_seq;
  import univ_shift_pkg::*;

  localparam int N  = 6;
  localparam int AW = $clog2(N) + 1;
`ifdef UNIV_SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] amt = '0;
  logic [N-1:0]  d = '0;
  logic          abort = 1'b0;
  logic          r_si = 1'b0;
  logic          l_si = 1'b0;
  logic [N-1:0]  q;
  logic          serial_out, busy, done;

  int checks = 0;
  int errors = 0;

  univ_shift_seq #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .amt        (amt),
    .d          (d),
    .abort      (abort),
    .r_serialin (r_si),
    .l_serialin (l_si),
    .q          (q),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-word arithmetic on the register value.
  function automatic logic [N-1:0] mstep(input logic [2:0] o, input logic [N-1:0] v,
                                         input logic rs, input logic ls, output logic so);
    int x, s;
    x = int'(v);
    s = v[N-1] ? x - (1 << N) : x;
    case (o)
      OP_SHR:  begin so = v[0];   mstep = N'((x >> 1) + (int'(rs) << (N-1))); end
      OP_SHL:  begin so = v[N-1]; mstep = N'((x << 1) + int'(ls)); end
      OP_ROR:  begin so = v[0];   mstep = N'((x >> 1) + ((x & 1) << (N-1))); end
      OP_ROL:  begin so = v[N-1]; mstep = N'((x << 1) + (x >> (N-1))); end
      OP_ASR:  begin so = v[0];   mstep = N'(s >>> 1); end
      default: begin so = 1'b0;   mstep = v; end
    endcase
  endfunction

  function automatic bit counts_steps(input logic [2:0] o);
    return (o == OP_SHR) || (o == OP_SHL) || (o == OP_ASR) ||
           (ROT_EN && ((o == OP_ROR) || (o == OP_ROL)));
  endfunction

  logic [N-1:0] m_q = '0;
  logic         m_so = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [2:0]   m_op = 3'd0;
  int           m_left = 0;

  always @(posedge clk or posedge rst) begin : model
    logic s;
    if (rst) begin
      m_q = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_op   = op;
          m_left = counts_steps(op) ? int'(amt) : 0;
          if (op == OP_LOAD) m_q = d;
        end
      end else if (abort) begin
        m_busy = 1'b0;
      end else begin
        if (m_left > 0) begin
          m_q  = mstep(m_op, m_q, r_si, l_si, s);
          m_so = s;
          m_left--;
        end
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("cmp_q",          32'(q),          32'(m_q));
    chk("cmp_serial_out", 32'(serial_out), 32'(m_so));
    chk("cmp_busy",       32'(busy),       32'(m_busy));
    chk("cmp_done",       32'(done),       32'(m_done));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input int a, input logic [N-1:0] dv);
    start = 1'b1; op = o; amt = AW'(a); d = dv;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    chk("reset_q",    32'(q), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_so",   32'(serial_out), 0);
    rst = 1'b0;

    issue(OP_LOAD, 0, 6'b101100);
    chk("load_q",     32'(q), 32'b101100);
    chk("load_busy",  32'(busy), 1);
    chk("load_done0", 32'(done), 0);
    cyc();
    chk("load_done",  32'(done), 1);
    chk("load_busy1", 32'(busy), 0);

    r_si = 1'b1;
    issue(OP_SHR, 2, '0);
    chk("shr_busy",  32'(busy), 1);
    cyc();
    chk("shr_q1",    32'(q), 32'b110110);
    chk("shr_done0", 32'(done), 0);
    cyc();
    chk("shr_q2",    32'(q), 32'b111011);
    chk("shr_so",    32'(serial_out), 0);
    chk("shr_done",  32'(done), 1);
    chk("shr_busy0", 32'(busy), 0);
    r_si = 1'b0;

    issue(OP_LOAD, 0, 6'b100000); cyc();
    issue(OP_ASR, 3, '0);
    repeat (3) cyc();
    chk("asr_q",    32'(q), 32'b111100);
    chk("asr_done", 32'(done), 1);

    issue(OP_LOAD, 0, 6'b101100); cyc();
    issue(OP_ROL, 6, '0);
`ifdef UNIV_SHIFT_ROTATE_EN
    repeat (5) cyc();
    chk("rol_q5",     32'(q), 32'b010110);
    chk("rol_done5",  32'(done), 0);
    cyc();
    chk("rol_q",      32'(q), 32'b101100);
    chk("rol_done",   32'(done), 1);
`else
    cyc();
    chk("rol_q",      32'(q), 32'b101100);
    chk("rol_done",   32'(done), 1);
`endif

    issue(OP_LOAD, 0, 6'b000001); cyc();
    l_si = 1'b0;
    issue(OP_SHL, 5, '0);
    start = 1'b1; op = OP_LOAD; d = 6'b111111;
    cyc();
    chk("shl_q1",   32'(q), 32'b000010);
    start = 1'b0;
    cyc();
    chk("shl_q2",   32'(q), 32'b000100);
    abort = 1'b1;
    cyc();
    chk("abort_q",    32'(q), 32'b000100);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    abort = 1'b0;
    cyc();
    chk("abort_done1", 32'(done), 0);

    issue(OP_SHR, 2, '0);
    cyc();
    chk("abl_q1", 32'(q), 32'b000010);
    abort = 1'b1;
    cyc();
    chk("abl_q2",    32'(q), 32'b000010);
    chk("abl_done",  32'(done), 0);
    chk("abl_busy",  32'(busy), 0);
    abort = 1'b0;
    cyc();
    chk("abl_done1", 32'(done), 0);

    issue(OP_SHL, 0, '0);
    chk("amt0_busy", 32'(busy), 1);
    cyc();
    chk("amt0_done", 32'(done), 1);
    chk("amt0_q",    32'(q), 32'b000010);
    issue(3'd7, 3, '0);
    chk("rsvd_busy", 32'(busy), 1);
    cyc();
    chk("rsvd_done", 32'(done), 1);
    chk("rsvd_q",    32'(q), 32'b000010);

    issue(OP_LOAD, 0, 6'b101100); cyc();
    issue(OP_SHR, 5, '0);
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("rst_q",    32'(q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    cyc();
    issue(OP_LOAD, 0, 6'b110011);
    chk("post_rst_q",    32'(q), 32'b110011);
    chk("post_rst_busy", 32'(busy), 1);

    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      amt   = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 15));
      d     = N'($urandom);
      r_si  = 1'($urandom_range(0, 1));
      l_si  = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      cyc();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (20) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_seq.md
# univ_shift_seq

Parametrised universal shift sequencer, the successor to the bidirectional shift register. It accepts a command holding an opcode, a shift amount and optional parallel data. It then executes the command one bit position per clock, covering logical, arithmetic and rotate shifts in either direction. Serial inputs are sampled live on each shift cycle, so the block also works as a streaming serialiser/deserialiser inside datapath and test-pattern logic.

## Interface
- n, default 8, register width (n >= 2)
- AW, default $clog2(n)+1, width of the shift-amount field (derived; do not override)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  command strobe, accepted only in IDLE
- op  input  3  opcode: 0 LOAD, 1 SHR, 2 SHL, 3 ROR, 4 ROL, 5 ASR, 6/7 reserved
- amt  input  AW  number of one-bit steps (0 .. 2^AW-1)
- d  input  n  parallel load data, used by LOAD only
- abort  input  1  terminates a running command
- r_serialin  input  1  bit entering q[n-1] on SHR
- l_serialin  input  1  bit entering q[0] on SHL
- q  output  n  register contents
- serial_out  output  1  registered copy of the last bit shifted or rotated out
- busy  output  1  command in progress
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN. Reset puts the FSM in IDLE and clears q, serial_out, busy, done and the internal count.
- IDLE with start=1, accepted at edge k:
  - op, amt latched.
  - busy=1 from edge k.
  - LOAD: q<=d at edge k itself; internal count=0.
- One step per edge while in RUN with count>0:
  - SHR: q<={r_serialin,q[n-1:1]}; serial_out<=q[0].
  - SHL: q<={q[n-2:0],l_serialin}; serial_out<=q[n-1].
  - ROR: q<={q[0],q[n-1:1]}; serial_out<=q[0].
  - ROL: q<={q[n-2:0],q[n-1]}; serial_out<=q[n-1].
  - ASR: q<={q[n-1],q[n-1:1]}; serial_out<=q[0].
- Completion: on the edge where count reaches 0, the FSM returns to IDLE, busy<=0 and done<=1 for one cycle.
- amt=0, LOAD, and reserved opcodes:
  - No shift; q unchanged (LOAD already applied at edge k).
  - done pulses after edge k+1.
- amt larger than n is legal; the block performs amt steps. A rotate by n restores the original value.
- start while busy is ignored, with no queuing.
- abort=1 in RUN: the FSM returns to IDLE at the next edge; q keeps its partial result; serial_out holds; done is not pulsed. abort in IDLE is ignored.
- If abort and the final step fall on the same edge, abort wins: no step is taken, q is not updated and no done pulse is issued.
- rst mid-command: immediate asynchronous clear of all state; the command is lost.

## Timing
- Command accepted at edge k, amt=m>0: steps occur at edges k+1..k+m; busy is high from edge k to edge k+m; done is high for the cycle following edge k+m.
- amt=0, LOAD, or reserved opcode: busy is high for exactly one cycle; done is high after edge k+1.
- Back-to-back: a new start is accepted in the cycle done is high (the FSM is already in IDLE), so throughput is m+1 cycles per command.
- r_serialin and l_serialin are sampled on each step edge, not latched at start.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- UNIV_SHIFT_ROTATE_EN defined: ROR and ROL behave as specified above.
- Not defined: opcodes 3 and 4 are decoded as reserved (one-cycle busy, done pulse, q unchanged) and the rotate mux legs are removed.

## Structure
- Package univ_shift_pkg holds:
  - Typedef op_t, an enum for LOAD, SHR, SHL, ROR, ROL, ASR and RSVD.
  - Typedef state_t (IDLE, RUN).
  - Opcode constants shared with the bench.
- Sub-module univ_shift_step: purely combinational single-step next-value function (inputs q, op, serial bits; outputs next q and the shifted-out bit). The top level holds the FSM, counter and registers.

## Test plan
- n=6, rst mid-SHR after 2 of 5 steps -> q=000000, busy=0, done=0 immediately; the next start is accepted normally.
- LOAD d=101100 -> q=101100 after the accept edge; done high one cycle later; busy high for exactly one cycle.
- SHR amt=2, r_serialin=1, from 101100 -> 110110 then 111011; serial_out=0; done after edge k+2.
- ASR amt=3 from 100000 -> 111100; ROL amt=6 from 101100 -> 101100; done after edge k+6. Rerun without UNIV_SHIFT_ROTATE_EN -> ROL leaves q unchanged with done after edge k+1.
- SHL amt=5 with abort asserted after 2 steps, from 000001 with l_serialin=0 -> q=000100, no done pulse. A start issued while busy is ignored.
- amt=0 SHL, and op=7 -> q unchanged, done after edge k+1. Back-to-back command issued in the done cycle is accepted.
